// File: rtl/nes_pkg.sv
// nes_pkg: shared timing constants, controller bit positions, the counter
// type and the tile-index helper for the nes_core picture generator.
package nes_pkg;

  localparam int unsigned DOTS_PER_LINE   = 341;
  localparam int unsigned LINES_PER_FRAME = 262;
  localparam int unsigned VIS_W           = 256;
  localparam int unsigned VIS_H           = 240;
  localparam int unsigned VBLANK_LINE     = 241;

  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  typedef logic [8:0] cnt9_t;

  // 8x8 grid of 32-pixel tiles: column in the upper three bits, row in the lower.
  function automatic logic [5:0] tile_idx(input logic [7:0] px, input logic [7:0] py);
    return {px[7:5], py[7:5]};
  endfunction

endpackage

// File: rtl/nes_timing.sv
// nes_timing: clock-enable divider plus PPU dot/line/frame-parity counters
// and registered h/v markers. Odd-frame dot skip is enabled by defining
// NES_ODD_FRAME_SKIP_EN.
module nes_timing
  import nes_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic  clk,
  input  logic  rst,
  output logic  tick,
  output cnt9_t dot_nxt,
  output cnt9_t line_nxt,
  output logic  h,
  output logic  v
);

  localparam int unsigned    PW         = $clog2(CLK_DIV);
  localparam logic [PW-1:0]  PHASE_LAST = PW'(CLK_DIV - 1);
  localparam cnt9_t          DOT_LAST   = cnt9_t'(DOTS_PER_LINE - 1);
  localparam cnt9_t          LINE_LAST  = cnt9_t'(LINES_PER_FRAME - 1);

  logic [PW-1:0] phase_q, phase_d;
  cnt9_t         dot_q, dot_d;
  cnt9_t         line_q, line_d;
  logic          frame_odd_q, frame_odd_d;
  logic          h_q, h_d;
  logic          v_q, v_d;
  cnt9_t         dot_last;

  // Next-state for divider, counters and line/frame-start markers.
  always_comb begin
    phase_d     = phase_q + PW'(1);
    tick        = (phase_q == PHASE_LAST);
    dot_d       = dot_q;
    line_d      = line_q;
    frame_odd_d = frame_odd_q;
    h_d         = h_q;
    v_d         = v_q;
    dot_last    = DOT_LAST;
`ifdef NES_ODD_FRAME_SKIP_EN
    if (frame_odd_q && (line_q == LINE_LAST)) dot_last = DOT_LAST - 9'd1;
`endif
    if (tick) begin
      // >= so the reset position (dot 340) still wraps if the last line is short.
      if (dot_q >= dot_last) begin
        dot_d = '0;
        if (line_q == LINE_LAST) begin
          line_d      = '0;
          frame_odd_d = ~frame_odd_q;
        end else begin
          line_d = line_q + 9'd1;
        end
      end else begin
        dot_d = dot_q + 9'd1;
      end
      h_d = (dot_d == '0);
      v_d = (dot_d == '0) && (line_d == '0);
    end
  end

  // Timing state register; frame_odd resets high so the first frame entered is even.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q     <= '0;
      dot_q       <= DOT_LAST;
      line_q      <= LINE_LAST;
      frame_odd_q <= 1'b1;
      h_q         <= 1'b0;
      v_q         <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      dot_q       <= dot_d;
      line_q      <= line_d;
      frame_odd_q <= frame_odd_d;
      h_q         <= h_d;
      v_q         <= v_d;
    end
  end

  assign dot_nxt  = dot_d;
  assign line_nxt = line_d;
  assign h        = h_q;
  assign v        = v_q;

endmodule

// File: rtl/nes_core.sv
// nes_core: scrollable tile test-pattern generator on NTSC PPU timing.
// Owns controller synchroniser, per-frame scroll/A state and the registered
// pixel output. Optional NES_ODD_FRAME_SKIP_EN shortens odd frames by one dot.
module nes_core
  import nes_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned SCROLL_STEP = 1,
  parameter logic [7:0]  BLANK_INDEX = 8'h0F
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] controller,
  output logic [7:0] pixel_out,
  output logic       h,
  output logic       v
);

  localparam logic [7:0] STEP = 8'(SCROLL_STEP);

  logic       tick;
  cnt9_t      dot_nxt, line_nxt;

  logic [7:0] sync1_q, sync1_d;
  logic [7:0] sync2_q, sync2_d;
  logic [7:0] scroll_x_q, scroll_x_d;
  logic [7:0] scroll_y_q, scroll_y_d;
  logic       a_q, a_d;
  logic [7:0] pixel_q, pixel_d;

  logic       sample;
  logic       visible;
  logic [7:0] px, py;
  logic       btn_unused;

  nes_timing #(
    .CLK_DIV(CLK_DIV)
  ) u_timing (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .dot_nxt (dot_nxt),
    .line_nxt(line_nxt),
    .h       (h),
    .v       (v)
  );

  assign btn_unused = sync2_q[BTN_B] ^ sync2_q[BTN_SELECT];

  // Controller synchroniser and vblank-start scroll/A update.
  always_comb begin
    sync1_d    = controller;
    sync2_d    = sync1_q;
    scroll_x_d = scroll_x_q;
    scroll_y_d = scroll_y_q;
    a_d        = a_q;
    sample     = tick && (line_nxt == cnt9_t'(VBLANK_LINE)) && (dot_nxt == 9'd1);
    if (sample) begin
      a_d = sync2_q[BTN_A];
      if (sync2_q[BTN_START]) begin
        scroll_x_d = '0;
        scroll_y_d = '0;
      end else begin
        if (sync2_q[BTN_RIGHT] && !sync2_q[BTN_LEFT])      scroll_x_d = scroll_x_q + STEP;
        else if (sync2_q[BTN_LEFT] && !sync2_q[BTN_RIGHT]) scroll_x_d = scroll_x_q - STEP;
        if (sync2_q[BTN_DOWN] && !sync2_q[BTN_UP])         scroll_y_d = scroll_y_q + STEP;
        else if (sync2_q[BTN_UP] && !sync2_q[BTN_DOWN])    scroll_y_d = scroll_y_q - STEP;
      end
    end
  end

  // Pixel for the dot being entered on this tick.
  always_comb begin
    px      = dot_nxt[7:0] + scroll_x_q;
    py      = line_nxt[7:0] + scroll_y_q;
    visible = (dot_nxt < cnt9_t'(VIS_W)) && (line_nxt < cnt9_t'(VIS_H));
    pixel_d = pixel_q;
    if (tick) begin
      pixel_d = visible ? {2'b00, tile_idx(px, py) ^ (a_q ? 6'h30 : 6'h00)} : BLANK_INDEX;
    end
  end

  // Synchroniser, scroll, A and pixel registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      scroll_x_q <= '0;
      scroll_y_q <= '0;
      a_q        <= 1'b0;
      pixel_q    <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      scroll_x_q <= scroll_x_d;
      scroll_y_q <= scroll_y_d;
      a_q        <= a_d;
      pixel_q    <= pixel_d;
    end
  end

  assign pixel_out = pixel_q;

endmodule

// File: tb/tb_nes_core.sv
// tb_nes_core: scoreboard bench for nes_core. Expected pixels are queued by
// frame/line/dot; a monitor walks an independent dot/line model and compares
// when the DUT reaches each queued position.
module tb_nes_core;

  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] controller = '0;
  logic [7:0] pixel_out;
  logic       h, v;

  nes_core #(
    .CLK_DIV    (CLK_DIV),
    .SCROLL_STEP(1),
    .BLANK_INDEX(8'h0F)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .controller(controller),
    .pixel_out (pixel_out),
    .h         (h),
    .v         (v)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int         frame;
    int         line;
    int         dot;
    logic [7:0] pix;
    logic       eh;
    logic       ev;
    string      name;
  } exp_t;

  exp_t sb[$];

  // Reference dot/line/frame model, advanced once per CLK_DIV clocks.
  int     m_ph, m_dot, m_line, m_frame;
  longint cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ph    <= 0;
      m_dot   <= 340;
      m_line  <= 261;
      m_frame <= -1;
    end else if (m_ph == CLK_DIV - 1) begin
      int last;
      last = 340;
`ifdef NES_ODD_FRAME_SKIP_EN
      if (m_line == 261 && (m_frame % 2) != 0) last = 339;
`endif
      m_ph <= 0;
      if (m_dot >= last) begin
        m_dot <= 0;
        if (m_line == 261) begin
          m_line  <= 0;
          m_frame <= m_frame + 1;
        end else begin
          m_line <= m_line + 1;
        end
      end else begin
        m_dot <= m_dot + 1;
      end
    end else begin
      m_ph <= m_ph + 1;
    end
  end

  function automatic longint key(input int f, input int l, input int d);
    return longint'(f) * 1000000 + longint'(l) * 1000 + longint'(d);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic push(input int f, input int d, input int l, input logic [7:0] p);
    exp_t e;
    e.frame = f;
    e.line  = l;
    e.dot   = d;
    e.pix   = p;
    e.eh    = (d == 0);
    e.ev    = (d == 0) && (l == 0);
    e.name  = $sformatf("f%0d(%0d,%0d)", f, d, l);
    sb.push_back(e);
  endtask

  task automatic wait_pos(input int f, input int l, input string what);
    int n;
    n = 0;
    while (!(m_frame > f || (m_frame == f && m_line >= l))) begin
      @(negedge clk);
      n++;
      if (n > 400000) begin
        tests++;
        fails++;
        $display("FAIL timeout_%s: at frame %0d line %0d, wanted frame %0d line %0d",
                 what, m_frame, m_line, f, l);
        return;
      end
    end
  endtask

  // Release reset away from the clock edge and check the first tick lands on edge CLK_DIV.
  task automatic release_and_check(input string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (CLK_DIV - 1) @(negedge clk);
    chk({tag, "_v_before_tick"}, 32'(v), 32'd0);
    @(negedge clk);
    chk({tag, "_v_at_tick"}, 32'(v), 32'd1);
    chk({tag, "_h_at_tick"}, 32'(h), 32'd1);
    repeat (CLK_DIV - 1) @(negedge clk);
    chk({tag, "_h_held"}, 32'(h), 32'd1);
    @(negedge clk);
    chk({tag, "_h_fall"}, 32'(h), 32'd0);
  endtask

  task automatic vblank(input int f, input logic [7:0] c);
    wait_pos(f, 239, "pre_vblank");
    #2 controller = c;
    wait_pos(f, 243, "post_vblank");
    #2 controller = '0;
  endtask

  // Monitor: scoreboard pops plus h/v period checks.
  initial begin
    logic   hp, vp;
    longint vlast, hlast, cur, expv;
    exp_t   e;
    hp = 1'b0; vp = 1'b0; vlast = -1; hlast = -1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        hp = 1'b0; vp = 1'b0; vlast = -1; hlast = -1;
      end else if (m_frame >= 0) begin
        cur = key(m_frame, m_line, m_dot);
        while (sb.size() > 0 && key(sb[0].frame, sb[0].line, sb[0].dot) <= cur) begin
          e = sb.pop_front();
          tests++;
          if (key(e.frame, e.line, e.dot) < cur) begin
            fails++;
            $display("FAIL %s: position passed unchecked (now f%0d (%0d,%0d))",
                     e.name, m_frame, m_dot, m_line);
          end else if (pixel_out !== e.pix || h !== e.eh || v !== e.ev) begin
            fails++;
            $display("FAIL %s: got pix=%02h h=%0b v=%0b, expected pix=%02h h=%0b v=%0b",
                     e.name, pixel_out, h, v, e.pix, e.eh, e.ev);
          end
        end
        if (v && !vp) begin
          if (vlast >= 0) begin
            expv = longint'(CLK_DIV) * 341 * 262;
`ifdef NES_ODD_FRAME_SKIP_EN
            if (((m_frame - 1) % 2) != 0) expv = expv - CLK_DIV;
`endif
            tests++;
            if (cyc - vlast != expv) begin
              fails++;
              $display("FAIL v_period: got %0d clks, expected %0d", cyc - vlast, expv);
            end
          end
          vlast = cyc;
        end
        if (h && !hp) begin
          if (hlast >= 0 && m_line >= 1 && m_line <= 3) begin
            tests++;
            if (cyc - hlast != longint'(CLK_DIV) * 341) begin
              fails++;
              $display("FAIL h_period line %0d: got %0d clks, expected %0d",
                       m_line, cyc - hlast, CLK_DIV * 341);
            end
          end
          hlast = cyc;
        end
        hp = h;
        vp = v;
      end
    end
  end

  // Stimulus.
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_pixel", 32'(pixel_out), 32'h00);
    chk("reset_h", 32'(h), 32'd0);
    chk("reset_v", 32'(v), 32'd0);

    // Frame 0: scroll (0,0), A off.
    push(0, 0, 0, 8'h00);
    push(0, 32, 0, 8'h08);
    push(0, 256, 0, 8'h0F);
    push(0, 0, 32, 8'h01);
    push(0, 255, 239, 8'h3F);
    push(0, 0, 240, 8'h0F);
    release_and_check("por");

    // Down+Right -> scroll (1,1).
    vblank(0, 8'hA0);
    push(1, 0, 0, 8'h00);
    push(1, 31, 0, 8'h08);
    push(1, 0, 31, 8'h01);
    push(1, 255, 239, 8'h07);

    // Left+Up -> scroll (0,0).
    vblank(1, 8'h50);
    push(2, 0, 0, 8'h00);
    push(2, 31, 0, 8'h00);
    push(2, 32, 0, 8'h08);
    push(2, 0, 31, 8'h00);
    push(2, 0, 32, 8'h01);

    // Left+Up from zero -> both axes wrap to 255.
    vblank(2, 8'h50);
    push(3, 0, 0, 8'h3F);
    push(3, 1, 0, 8'h07);
    push(3, 0, 1, 8'h38);
    push(3, 1, 1, 8'h00);

    // All four directions plus B/Select -> unchanged.
    vblank(3, 8'hF6);
    push(4, 0, 0, 8'h3F);
    push(4, 1, 1, 8'h00);
    push(4, 256, 1, 8'h0F);

    // A+Start with Down+Right -> scroll cleared, A inverts pattern.
    vblank(4, 8'hA9);
    push(5, 0, 0, 8'h30);
    push(5, 32, 0, 8'h38);
    push(5, 256, 0, 8'h0F);
    push(5, 0, 32, 8'h31);
    push(5, 255, 239, 8'h0F);

    wait_pos(5, 245, "frame5");
    chk("sb_drained_before_reset", 32'(sb.size()), 32'd0);

    // Mid-frame reset: outputs clear immediately, A state is cleared.
    #2 rst = 1'b0;
    #1;
    chk("midreset_pixel", 32'(pixel_out), 32'h00);
    chk("midreset_h", 32'(h), 32'd0);
    chk("midreset_v", 32'(v), 32'd0);
    repeat (3) @(negedge clk);
    push(0, 0, 0, 8'h00);
    push(0, 32, 0, 8'h08);
    push(0, 0, 32, 8'h01);
    release_and_check("rst2");

    wait_pos(0, 40, "after_reset");
    chk("sb_drained_end", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
